// File: rtl/nanomamba_expert_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : nanomamba_expert_scheduler
// Purpose  : Per-frame sequencer placed after the MOE router. It latches the
//            Q0.8 gate and picks an execution mode (E0 only, E1 only, both)
//            with hysteresis. It clock-enables and starts the selected expert
//            engines, waits for their completion, launches the blend stage
//            with the effective gate, and reports frame completion. A
//            per-frame watchdog aborts a frame that stalls.
// Ports    : clk, rst            - clock, synchronous active-high reset
//            i_gate_in/_valid    - router gate and its one-cycle qualifier
//            i_cfg_force         - 00 auto, 01 E0, 10 E1, 11 both
//            o_frame_ready       - scheduler idle, gate accepted
//            o_exp*_clk_en       - expert clock enables
//            o_exp*_start        - expert start pulses
//            i_exp*_done         - expert completion pulses
//            o_blend_start/_gate - blend launch pulse and effective gate
//            i_blend_done        - blend completion pulse
//            o_mode              - last decided mode
//            o_frame_done/_err   - end-of-frame pulse, abort flag
//            o_overrun           - sticky: gate dropped while busy
//            o_timeout_err       - sticky: a frame timed out
//            o_stat_*            - saturating frame statistics (optional)
// Options  : define SCHED_STATS_EN to add the statistics counters/ports.
// Revision : 1.0 - initial release
// ============================================================================
module nanomamba_expert_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int TH_LO      = 64,
  parameter int TH_HI      = 192,
  parameter int HYST       = 8,
  parameter int WAKE_CYC   = 2,
  parameter int TIMEOUT    = 1023,
  parameter int TO_W       = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] i_gate_in,
  input  logic                  i_gate_valid,
  input  logic [1:0]            i_cfg_force,
  output logic                  o_frame_ready,
  output logic                  o_exp0_clk_en,
  output logic                  o_exp1_clk_en,
  output logic                  o_exp0_start,
  output logic                  o_exp1_start,
  input  logic                  i_exp0_done,
  input  logic                  i_exp1_done,
  output logic                  o_blend_start,
  output logic [DATA_WIDTH-1:0] o_blend_gate,
  input  logic                  i_blend_done,
  output logic [1:0]            o_mode,
  output logic                  o_frame_done,
  output logic                  o_frame_err,
  output logic                  o_overrun,
  output logic                  o_timeout_err
`ifdef SCHED_STATS_EN
  ,
  output logic [15:0]           o_stat_e0,
  output logic [15:0]           o_stat_e1,
  output logic [15:0]           o_stat_both,
  output logic [7:0]            o_stat_to
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAKE  = 3'd1,
    S_RUN   = 3'd2,
    S_BLEND = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  // Two extra bits keep threshold sums/differences free of wrap-around.
  localparam int                c_CW       = DATA_WIDTH + 2;
  localparam logic [c_CW-1:0]   c_TH_LO    = c_CW'(TH_LO);
  localparam logic [c_CW-1:0]   c_TH_HI    = c_CW'(TH_HI);
  localparam logic [c_CW-1:0]   c_LO_HOLD  = c_CW'(TH_LO + HYST);
  localparam logic [c_CW-1:0]   c_HYST     = c_CW'(HYST);
  localparam logic [3:0]        c_WAKE     = 4'(WAKE_CYC);
  localparam logic [TO_W-1:0]   c_TO_LAST  = TO_W'(TIMEOUT - 1);

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_gate;
  logic [3:0]            r_wake_cnt;
  logic [TO_W-1:0]       r_to_cnt;
  logic                  r_run_first;
  logic                  r_blend_first;
  logic                  r_d0;
  logic                  r_d1;

  logic [c_CW-1:0]       w_g_ext;
  logic                  w_below_lo;
  logic                  w_above_hi;
  logic                  w_hold_e0;
  logic                  w_hold_e1;
  logic [1:0]            w_auto_mode;
  logic [1:0]            w_new_mode;
  logic                  w_d0_now;
  logic                  w_d1_now;
  logic                  w_all_done;
  logic                  w_to_hit;
  logic [DATA_WIDTH-1:0] w_blend_val;

  // --------------------------------------------------------------------------
  // Mode decision. o_mode doubles as the previous-frame mode for hysteresis.
  // --------------------------------------------------------------------------
  always_comb begin
    w_g_ext    = {2'b00, i_gate_in};
    w_below_lo = (w_g_ext < c_TH_LO);
    w_above_hi = (w_g_ext > c_TH_HI);
    w_hold_e0  = (w_g_ext < c_LO_HOLD);
    // gate > TH_HI - HYST rewritten so a large HYST cannot underflow
    w_hold_e1  = ((w_g_ext + c_HYST) > c_TH_HI);

    w_auto_mode = 2'b11;
    if (o_mode == 2'b01 && w_hold_e0) begin
      w_auto_mode = 2'b01;
    end else if (o_mode == 2'b10 && w_hold_e1) begin
      w_auto_mode = 2'b10;
    end else if (w_below_lo) begin
      w_auto_mode = 2'b01;
    end else if (w_above_hi) begin
      w_auto_mode = 2'b10;
    end

    w_new_mode = (i_cfg_force != 2'b00) ? i_cfg_force : w_auto_mode;
  end

  // --------------------------------------------------------------------------
  // Completion tracking. A done pulse during the start cycle is too early to
  // belong to this frame, so it is masked; unselected experts never count.
  // --------------------------------------------------------------------------
  always_comb begin
    w_d0_now    = i_exp0_done & o_mode[0] & ~r_run_first;
    w_d1_now    = i_exp1_done & o_mode[1] & ~r_run_first;
    w_all_done  = (~o_mode[0] | r_d0 | w_d0_now) &
                  (~o_mode[1] | r_d1 | w_d1_now);
    w_to_hit    = (r_to_cnt == c_TO_LAST);
    w_blend_val = r_gate;
    if (o_mode == 2'b01) begin
      w_blend_val = '0;
    end else if (o_mode == 2'b10) begin
      w_blend_val = '1;
    end
  end

  // --------------------------------------------------------------------------
  // Frame sequencer with registered outputs.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_gate        <= '0;
      r_wake_cnt    <= '0;
      r_to_cnt      <= '0;
      r_run_first   <= 1'b0;
      r_blend_first <= 1'b0;
      r_d0          <= 1'b0;
      r_d1          <= 1'b0;
      o_frame_ready <= 1'b1;
      o_exp0_clk_en <= 1'b0;
      o_exp1_clk_en <= 1'b0;
      o_exp0_start  <= 1'b0;
      o_exp1_start  <= 1'b0;
      o_blend_start <= 1'b0;
      o_blend_gate  <= '0;
      o_mode        <= 2'b11;
      o_frame_done  <= 1'b0;
      o_frame_err   <= 1'b0;
      o_overrun     <= 1'b0;
      o_timeout_err <= 1'b0;
    end else begin
      // single-cycle pulses default low
      o_exp0_start  <= 1'b0;
      o_exp1_start  <= 1'b0;
      o_blend_start <= 1'b0;
      o_frame_done  <= 1'b0;
      o_frame_err   <= 1'b0;

      if (i_gate_valid && r_state != S_IDLE) begin
        o_overrun <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (i_gate_valid) begin
            r_gate        <= i_gate_in;
            o_mode        <= w_new_mode;
            o_exp0_clk_en <= w_new_mode[0];
            o_exp1_clk_en <= w_new_mode[1];
            o_frame_ready <= 1'b0;
            r_wake_cnt    <= 4'd1;
            r_state       <= S_WAKE;
          end
        end

        S_WAKE: begin
          if (r_wake_cnt >= c_WAKE) begin
            o_exp0_start <= o_mode[0];
            o_exp1_start <= o_mode[1];
            r_run_first  <= 1'b1;
            r_d0         <= 1'b0;
            r_d1         <= 1'b0;
            r_to_cnt     <= '0;
            r_state      <= S_RUN;
          end else begin
            r_wake_cnt <= r_wake_cnt + 4'd1;
          end
        end

        S_RUN: begin
          r_run_first <= 1'b0;
          r_to_cnt    <= r_to_cnt + 1'b1;
          // completion takes priority over a coincident timeout
          if (w_all_done) begin
            o_blend_start <= 1'b1;
            o_blend_gate  <= w_blend_val;
            r_blend_first <= 1'b1;
            r_state       <= S_BLEND;
          end else if (w_to_hit) begin
            o_frame_done  <= 1'b1;
            o_frame_err   <= 1'b1;
            o_timeout_err <= 1'b1;
            o_exp0_clk_en <= 1'b0;
            o_exp1_clk_en <= 1'b0;
            r_state       <= S_FIN;
          end else begin
            r_d0 <= r_d0 | w_d0_now;
            r_d1 <= r_d1 | w_d1_now;
          end
        end

        S_BLEND: begin
          r_blend_first <= 1'b0;
          r_to_cnt      <= r_to_cnt + 1'b1;
          if (i_blend_done && !r_blend_first) begin
            o_frame_done  <= 1'b1;
            o_exp0_clk_en <= 1'b0;
            o_exp1_clk_en <= 1'b0;
            r_state       <= S_FIN;
          end else if (w_to_hit) begin
            o_frame_done  <= 1'b1;
            o_frame_err   <= 1'b1;
            o_timeout_err <= 1'b1;
            o_exp0_clk_en <= 1'b0;
            o_exp1_clk_en <= 1'b0;
            r_state       <= S_FIN;
          end
        end

        S_FIN: begin
          o_frame_ready <= 1'b1;
          r_state       <= S_IDLE;
        end

        default: begin
          o_frame_ready <= 1'b1;
          o_exp0_clk_en <= 1'b0;
          o_exp1_clk_en <= 1'b0;
          r_state       <= S_IDLE;
        end
      endcase
    end
  end

`ifdef SCHED_STATS_EN
  // --------------------------------------------------------------------------
  // Saturating statistics, updated during the frame_done cycle.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      o_stat_e0   <= '0;
      o_stat_e1   <= '0;
      o_stat_both <= '0;
      o_stat_to   <= '0;
    end else if (o_frame_done) begin
      if (o_frame_err) begin
        if (o_stat_to != '1) o_stat_to <= o_stat_to + 8'd1;
      end else begin
        case (o_mode)
          2'b01:   if (o_stat_e0 != '1)   o_stat_e0   <= o_stat_e0 + 16'd1;
          2'b10:   if (o_stat_e1 != '1)   o_stat_e1   <= o_stat_e1 + 16'd1;
          default: if (o_stat_both != '1) o_stat_both <= o_stat_both + 16'd1;
        endcase
      end
    end
  end
`else
  // statistics counters are not built in this configuration
`endif

endmodule
`default_nettype wire
